// File: rtl/fp_unpack_norm.sv
// fp_unpack_norm: unpacks an IEEE-754 operand into sign, unbiased exponent and a
// normalized significand (hidden/leading one at MSB) plus a one-hot class.
// Two-stage valid/ready pipeline, one operand per cycle.
// Build option: FP_UNPACK_DAZ_EN (defined = subnormal inputs treated as signed zero).
module fp_unpack_norm #(
  parameter int unsigned NEXP = 8,
  parameter int unsigned NSIG = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NEXP+NSIG:0]     in_fp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_neg,
  output logic signed [NEXP+1:0] out_exp,
  output logic [NSIG:0]          out_sig,
  output logic [5:0]             out_class
);

  localparam int unsigned EW   = NEXP + 2;
  localparam int unsigned SW   = NSIG + 1;
  localparam int          BIAS = 2 ** (NEXP - 1) - 1;
  localparam int          EMAX = BIAS;
`ifndef FP_UNPACK_DAZ_EN
  localparam int          EMIN = 1 - BIAS;
  localparam int unsigned LZW  = $clog2(NSIG);
`endif

  // one-hot class bit positions: {snan, qnan, inf, zero, subnormal, normal}
  localparam int unsigned C_NORM = 0;
  localparam int unsigned C_SUB  = 1;
  localparam int unsigned C_ZERO = 2;
  localparam int unsigned C_INF  = 3;
  localparam int unsigned C_QNAN = 4;
  localparam int unsigned C_SNAN = 5;

  logic            s1V;
  logic            s1Neg;
  logic [NEXP-1:0] s1E;
  logic [NSIG-1:0] s1F;
  logic [5:0]      s1Class;
  logic            s1En;
  logic            s2En;

  logic [NEXP-1:0] inE;
  logic [NSIG-1:0] inF;
  logic [5:0]      inClass;

  logic signed [EW-1:0] nExp;
  logic [SW-1:0]        nSig;

`ifndef FP_UNPACK_DAZ_EN
  logic [LZW-1:0] inLz;
  logic [LZW-1:0] s1Lz;
  logic           lzFound;
  logic [LZW:0]   shAmt;
`endif

  // Handshake: a stage advances when it is empty or the stage after it advances.
  assign s2En     = !out_valid || out_ready;
  assign s1En     = !s1V || s2En;
  assign in_ready = s1En;

  assign inE = in_fp[NEXP+NSIG-1:NSIG];
  assign inF = in_fp[NSIG-1:0];

  // Classify the incoming operand from its exponent and fraction fields.
  always_comb begin
    inClass = '0;
    if (&inE) begin
      if (~|inF)          inClass[C_INF]  = 1'b1;
      else if (inF[NSIG-1]) inClass[C_QNAN] = 1'b1;
      else                inClass[C_SNAN] = 1'b1;
    end else if (~|inE) begin
      if (~|inF)          inClass[C_ZERO] = 1'b1;
`ifdef FP_UNPACK_DAZ_EN
      else                inClass[C_ZERO] = 1'b1;
`else
      else                inClass[C_SUB]  = 1'b1;
`endif
    end else begin
      inClass[C_NORM] = 1'b1;
    end
  end

`ifndef FP_UNPACK_DAZ_EN
  // Leading-zero count of the fraction (only used to normalize subnormals).
  always_comb begin
    inLz    = '0;
    lzFound = 1'b0;
    for (int i = int'(NSIG) - 1; i >= 0; i--) begin
      if (!lzFound && inF[i]) begin
        inLz    = LZW'(int'(NSIG) - 1 - i);
        lzFound = 1'b1;
      end
    end
  end
`endif

  // Stage 1 register: raw fields, class and leading-zero count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1V     <= 1'b0;
      s1Neg   <= 1'b0;
      s1E     <= '0;
      s1F     <= '0;
      s1Class <= '0;
`ifndef FP_UNPACK_DAZ_EN
      s1Lz    <= '0;
`endif
    end else if (s1En) begin
      s1V <= in_valid;
      if (in_valid) begin
        s1Neg   <= in_fp[NEXP+NSIG];
        s1E     <= inE;
        s1F     <= inF;
        s1Class <= inClass;
`ifndef FP_UNPACK_DAZ_EN
        s1Lz    <= inLz;
`endif
      end
    end
  end

  // Stage 2 datapath: unbiased exponent and normalized significand per class.
  always_comb begin
    nExp = '0;
    nSig = '0;
`ifndef FP_UNPACK_DAZ_EN
    shAmt = (LZW+1)'(s1Lz) + (LZW+1)'(1);
`endif
    if (s1Class[C_NORM]) begin
      nExp = EW'(s1E) - EW'(BIAS);
      nSig = {1'b1, s1F};
`ifndef FP_UNPACK_DAZ_EN
    end else if (s1Class[C_SUB]) begin
      nExp = EW'(EMIN) - EW'(s1Lz) - EW'(1);
      nSig = {1'b0, s1F} << shAmt;
`endif
    end else if (s1Class[C_INF]) begin
      nExp = EW'(EMAX + 1);
      nSig = {1'b1, {NSIG{1'b0}}};
    end else if (s1Class[C_QNAN] || s1Class[C_SNAN]) begin
      // NaN payload passes through untouched (no quieting here)
      nExp = EW'(EMAX + 1);
      nSig = {1'b1, s1F};
    end
  end

  // Stage 2 register: outputs hold while stalled by out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_neg   <= 1'b0;
      out_exp   <= '0;
      out_sig   <= '0;
      out_class <= '0;
    end else if (s2En) begin
      out_valid <= s1V;
      if (s1V) begin
        out_neg   <= s1Neg;
        out_exp   <= nExp;
        out_sig   <= nSig;
        out_class <= s1Class;
      end
    end
  end

endmodule

// File: tb/tb_fp_unpack_norm.sv
// tb_fp_unpack_norm: directed bench for fp_unpack_norm at NEXP=8, NSIG=23.
// Honours FP_UNPACK_DAZ_EN for the subnormal expectations.
module tb_fp_unpack_norm;

  localparam logic [5:0] CN  = 6'b000001;
  localparam logic [5:0] CS  = 6'b000010;
  localparam logic [5:0] CZ  = 6'b000100;
  localparam logic [5:0] CI  = 6'b001000;
  localparam logic [5:0] CQ  = 6'b010000;
  localparam logic [5:0] CSN = 6'b100000;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_fp;
  logic              out_valid;
  logic              out_ready;
  logic              out_neg;
  logic signed [9:0] out_exp;
  logic [23:0]       out_sig;
  logic [5:0]        out_class;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    logic [31:0] fp;
    logic        neg;
    int          ex;
    logic [23:0] sig;
    logic [5:0]  cls;
    string       name;
  } vec_t;

  vec_t vecs[$];

  fp_unpack_norm #(.NEXP(8), .NSIG(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_fp(in_fp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_neg(out_neg), .out_exp(out_exp), .out_sig(out_sig), .out_class(out_class)
  );

  always #5 clk = ~clk;

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic addVec(input logic [31:0] fp, input logic neg, input int ex,
                        input logic [23:0] sig, input logic [5:0] cls, input string name);
    vec_t t;
    t.fp = fp; t.neg = neg; t.ex = ex; t.sig = sig; t.cls = cls; t.name = name;
    vecs.push_back(t);
  endtask

  // Drive one operand into an empty pipeline and capture its result.
  task automatic apply(input logic [31:0] fp, output int lat, output logic neg,
                       output logic signed [9:0] e, output logic [23:0] s, output logic [5:0] c);
    @(negedge clk);
    in_fp = fp; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0; neg = 1'b0; e = '0; s = '0; c = '0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = k; neg = out_neg; e = out_exp; s = out_sig; c = out_class;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_fp = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    nTests++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    nTests++; if (out_neg !== 1'b0) begin nFail++; $display("FAIL reset out_neg: got %b want 0", out_neg); end
    nTests++; if (out_exp !== 10'd0) begin nFail++; $display("FAIL reset out_exp: got %0d want 0", out_exp); end
    nTests++; if (out_sig !== 24'd0) begin nFail++; $display("FAIL reset out_sig: got %h want 0", out_sig); end
    nTests++; if (out_class !== 6'd0) begin nFail++; $display("FAIL reset out_class: got %b want 0", out_class); end
    nTests++; if (in_ready !== 1'b1) begin nFail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_classes();
    int lat; logic neg; logic signed [9:0] e; logic [23:0] s; logic [5:0] c;
    addVec(32'h3F800000, 1'b0,    0, 24'h800000, CN,  "one");
    addVec(32'h7F7FFFFF, 1'b0,  127, 24'hFFFFFF, CN,  "max_normal");
    addVec(32'h00800000, 1'b0, -126, 24'h800000, CN,  "min_normal");
`ifdef FP_UNPACK_DAZ_EN
    addVec(32'h00000001, 1'b0,    0, 24'h000000, CZ,  "daz_min_sub");
    addVec(32'h00400000, 1'b0,    0, 24'h000000, CZ,  "daz_sub_msb");
    addVec(32'h807FFFFF, 1'b1,    0, 24'h000000, CZ,  "daz_neg_sub");
`else
    addVec(32'h00000001, 1'b0, -149, 24'h800000, CS,  "min_sub");
    addVec(32'h00400000, 1'b0, -127, 24'h800000, CS,  "sub_msb");
    addVec(32'h00000003, 1'b0, -148, 24'hC00000, CS,  "sub_3");
    addVec(32'h807FFFFF, 1'b1, -127, 24'hFFFFFE, CS,  "neg_max_sub");
`endif
    addVec(32'h80000000, 1'b1,    0, 24'h000000, CZ,  "neg_zero");
    addVec(32'hFF800000, 1'b1,  128, 24'h800000, CI,  "neg_inf");
    addVec(32'h7F800001, 1'b0,  128, 24'h800001, CSN, "snan");
    addVec(32'h7FC00000, 1'b0,  128, 24'hC00000, CQ,  "qnan");
    addVec(32'hFFFFFFFF, 1'b1,  128, 24'hFFFFFF, CQ,  "neg_qnan_payload");
    foreach (vecs[i]) begin
      apply(vecs[i].fp, lat, neg, e, s, c);
      nTests++; if (lat !== 2) begin nFail++; $display("FAIL %s latency: got %0d want 2", vecs[i].name, lat); end
      nTests++; if (neg !== vecs[i].neg) begin nFail++; $display("FAIL %s neg: got %b want %b", vecs[i].name, neg, vecs[i].neg); end
      nTests++; if (int'(e) !== vecs[i].ex) begin nFail++; $display("FAIL %s exp: got %0d want %0d", vecs[i].name, e, vecs[i].ex); end
      nTests++; if (s !== vecs[i].sig) begin nFail++; $display("FAIL %s sig: got %h want %h", vecs[i].name, s, vecs[i].sig); end
      nTests++; if (c !== vecs[i].cls) begin nFail++; $display("FAIL %s class: got %b want %b", vecs[i].name, c, vecs[i].cls); end
    end
  endtask

  // Stream four operands; out_ready held low for the first 'stall' cycles.
  task automatic run_stream(input int stall, input string tag);
    logic [31:0] ops[4];
    int          ex[4];
    logic [23:0] sg[4];
    int          inIdx, outIdx, firstOut, lastOut;
    logic [23:0] heldSig;
    logic        fireIn, fireOut;
    ops[0] = 32'h3FC00000; ex[0] = 0; sg[0] = 24'hC00000;
    ops[1] = 32'h40A00000; ex[1] = 2; sg[1] = 24'hA00000;
    ops[2] = 32'h3F800001; ex[2] = 0; sg[2] = 24'h800001;
    ops[3] = 32'h41100000; ex[3] = 3; sg[3] = 24'h900000;
    inIdx = 0; outIdx = 0; firstOut = -1; lastOut = -1; heldSig = '0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_fp = ops[0]; out_ready = (stall == 0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      fireIn  = in_valid && in_ready;
      fireOut = out_valid && out_ready;
      if (stall == 0 && inIdx < 4) begin
        nTests++; if (in_ready !== 1'b1) begin nFail++; $display("FAIL %s in_ready cyc %0d: got %b want 1", tag, cyc, in_ready); end
      end
      if (stall > 0 && cyc == stall - 1) begin
        nTests++; if (inIdx !== 2) begin nFail++; $display("FAIL %s accepted while stalled: got %0d want 2", tag, inIdx); end
        nTests++; if (in_ready !== 1'b0) begin nFail++; $display("FAIL %s in_ready while full: got %b want 0", tag, in_ready); end
      end
      if (stall > 0 && cyc >= 2 && cyc < stall) begin
        if (cyc == 2) heldSig = out_sig;
        nTests++; if (out_valid !== 1'b1 || out_sig !== sg[0]) begin nFail++; $display("FAIL %s held output cyc %0d: got v=%b sig=%h want v=1 sig=%h", tag, cyc, out_valid, out_sig, sg[0]); end
        nTests++; if (out_sig !== heldSig) begin nFail++; $display("FAIL %s output unstable cyc %0d: got %h want %h", tag, cyc, out_sig, heldSig); end
      end
      if (fireOut) begin
        if (outIdx < 4) begin
          nTests++; if (out_sig !== sg[outIdx]) begin nFail++; $display("FAIL %s out%0d sig: got %h want %h", tag, outIdx, out_sig, sg[outIdx]); end
          nTests++; if (int'(out_exp) !== ex[outIdx]) begin nFail++; $display("FAIL %s out%0d exp: got %0d want %0d", tag, outIdx, out_exp, ex[outIdx]); end
        end else begin
          nTests++; nFail++; $display("FAIL %s extra output: got sig %h want none", tag, out_sig);
        end
        if (firstOut < 0) firstOut = cyc;
        lastOut = cyc;
        outIdx++;
      end
      @(posedge clk); #1;
      if (fireIn) inIdx++;
      if (inIdx < 4) begin
        in_valid = 1'b1; in_fp = ops[inIdx];
      end else begin
        in_valid = 1'b0; in_fp = '0;
      end
      out_ready = (cyc + 1 >= stall);
    end
    nTests++; if (outIdx !== 4) begin nFail++; $display("FAIL %s output count: got %0d want 4", tag, outIdx); end
    nTests++; if (lastOut - firstOut !== 3) begin nFail++; $display("FAIL %s drain span: got %0d want 3", tag, lastOut - firstOut); end
    nTests++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL %s idle out_valid: got %b want 0", tag, out_valid); end
  endtask

  task automatic test_back_to_back();
    run_stream(0, "b2b");
  endtask

  task automatic test_backpressure();
    run_stream(5, "bp");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_fp = 32'h3F800000; out_ready = 1'b0;
    @(negedge clk);
    in_fp = 32'h40A00000;
    @(negedge clk);
    in_valid = 1'b0;
    nTests++; if (out_valid !== 1'b1) begin nFail++; $display("FAIL rstmid pre out_valid: got %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    nTests++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL rstmid async out_valid: got %b want 0", out_valid); end
    nTests++; if (out_sig !== 24'd0 || out_class !== 6'd0) begin nFail++; $display("FAIL rstmid async data: got sig=%h cls=%b want 0", out_sig, out_class); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      nTests++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL rstmid stale output cyc %0d: got %b want 0", k, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_classes();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
